// File: rtl/fft4_pkg.sv
// Shared types and index helpers for the radix-4 DIF stage scheduler.
// FSM encoding, lane count, span/twiddle exponent functions.
package fft4_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

  // Butterfly lanes; each packed address/twiddle bus holds LANES slices.
  localparam int LANES = 4;

  // Width of one packed address or twiddle slice.
  function automatic int lane_w(input int log4n);
    return 2 * log4n;
  endfunction

  // log2 of the butterfly span in stage s.
  function automatic int span_sh(input int s, input int log4n);
    return 2 * (log4n - 1 - s);
  endfunction

  // span = N >> (2*(s+1))
  function automatic int digit_span(input int s, input int log4n);
    return 1 << span_sh(s, log4n);
  endfunction

  // Twiddle exponent before the mod-N reduction done by truncation.
  function automatic int tw_exp(input int m, input int j, input int s);
    return m * j * (1 << (2 * s));
  endfunction

endpackage

// File: rtl/fft4_delay_line.sv
// Valid+payload shift register, DEPTH stages, synchronously cleared.
// Ports: clk_i, rst_i, vld_i/dat_i in; vld_o/dat_o out; pend_o = valid not in last stage.
module fft4_delay_line #(
  parameter int DEPTH = 1,
  parameter int W     = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         vld_i,
  input  logic [W-1:0] dat_i,
  output logic         vld_o,
  output logic [W-1:0] dat_o,
  output logic         pend_o
);

  logic [DEPTH-1:0] vld_q;
  logic [W-1:0]     dat_q [DEPTH];
  logic [DEPTH-1:0] keep;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dat_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= vld_i;
      dat_q[0] <= dat_i;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  // An entry in the last stage leaves on the next edge, so it does
  // not count as still pending.
  always_comb begin
    keep          = '1;
    keep[DEPTH-1] = 1'b0;
    pend_o        = |(vld_q & keep);
  end

  assign vld_o = vld_q[DEPTH-1];
  assign dat_o = dat_q[DEPTH-1];

endmodule

// File: rtl/fft4_stage_scheduler.sv
// Issue/drain sequencer for an in-place radix-4 DIF FFT (N = 4^LOG4_N).
// In: sys_clk_i, rst_i, start_i, hold_i. Out: busy_o, done_o, stage_o,
// rd_en_o/rd_addr_o, bf_valid_o/tw_idx_o, wr_en_o/wr_addr_o.
// FFT4_SCHED_PERF_EN adds perf_cycles_o (busy cycle counter).
module fft4_stage_scheduler
  import fft4_pkg::*;
#(
  parameter  int LOG4_N     = 2,
  parameter  int RD_LATENCY = 1,
  parameter  int BF_LATENCY = 1,
  localparam int AW         = lane_w(LOG4_N),
  localparam int L          = RD_LATENCY + BF_LATENCY,
  localparam int SW         = (LOG4_N < 1) ? 1 : LOG4_N
) (
  input  logic              sys_clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              hold_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [SW-1:0]     stage_o,
  output logic              rd_en_o,
  output logic [4*AW-1:0]   rd_addr_o,
  output logic              bf_valid_o,
  output logic [4*AW-1:0]   tw_idx_o,
  output logic              wr_en_o,
  output logic [4*AW-1:0]   wr_addr_o
`ifdef FFT4_SCHED_PERF_EN
  ,
  output logic [31:0]       perf_cycles_o
`endif
);

  localparam int NB = (1 << AW) / 4;

  state_e          state_q, state_d;
  logic [SW-1:0]   stage_q, stage_d;
  logic [AW-1:0]   b_q, b_d;
  logic            rd_en;
  logic            pend;
  logic            bf_pend;
  logic            wr_pend;
  logic [4*AW-1:0] addr_v;
  logic [4*AW-1:0] tw_v;
  int              sh;
  int              span;
  int              g;
  int              j;

  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      stage_q <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      b_q     <= b_d;
    end
  end

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    b_d     = b_q;
    rd_en   = 1'b0;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_RUN;
          stage_d = '0;
          b_d     = '0;
        end
      end
      ST_RUN: begin
        busy_o = 1'b1;
        if (!hold_i) begin
          rd_en = 1'b1;
          if (b_q == AW'(NB - 1)) begin
            state_d = ST_DRAIN;
            b_d     = '0;
          end else begin
            b_d = b_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        busy_o = 1'b1;
        if (!pend) begin
          if (stage_q == SW'(LOG4_N - 1)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
            stage_d = stage_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        done_o  = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Butterfly b splits into group g and offset j within the span.
  // Non-issue cycles carry zero payload so idle outputs stay at 0.
  always_comb begin
    sh     = span_sh(int'(stage_q), LOG4_N);
    span   = 1 << sh;
    g      = int'(b_q) >> sh;
    j      = int'(b_q) & (span - 1);
    addr_v = '0;
    tw_v   = '0;
    if (rd_en) begin
      for (int m = 0; m < LANES; m++) begin
        addr_v[m*AW +: AW] = AW'(g * 4 * span + j + m * span);
        tw_v[m*AW +: AW]   = AW'(tw_exp(m, j, int'(stage_q)));
      end
    end
  end

  fft4_delay_line #(
    .DEPTH (RD_LATENCY),
    .W     (4*AW)
  ) u_bf_line (
    .clk_i  (sys_clk_i),
    .rst_i  (rst_i),
    .vld_i  (rd_en),
    .dat_i  (tw_v),
    .vld_o  (bf_valid_o),
    .dat_o  (tw_idx_o),
    .pend_o (bf_pend)
  );

  fft4_delay_line #(
    .DEPTH (L),
    .W     (4*AW)
  ) u_wr_line (
    .clk_i  (sys_clk_i),
    .rst_i  (rst_i),
    .vld_i  (rd_en),
    .dat_i  (addr_v),
    .vld_o  (wr_en_o),
    .dat_o  (wr_addr_o),
    .pend_o (wr_pend)
  );

  // Leave DRAIN in the cycle of the final write so the next stage's
  // first read lands right after it.
  assign pend      = wr_pend | bf_pend;
  assign rd_en_o   = rd_en;
  assign rd_addr_o = addr_v;
  assign stage_o   = stage_q;

`ifdef FFT4_SCHED_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      perf_q <= '0;
    end else if (state_q == ST_IDLE) begin
      if (start_i) perf_q <= '0;
    end else if (perf_q != 32'hFFFF_FFFF) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_cycles_o = perf_q;
`endif

endmodule

// File: tb/tb_fft4_stage_scheduler.sv
// Directed bench for fft4_stage_scheduler at N=16, L=2.
// Checks issue order, timing, hold, ignored starts and reset abort.
module tb_fft4_stage_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        hold;
  logic        busy;
  logic        done;
  logic [1:0]  stage;
  logic        rd_en;
  logic [15:0] rd_addr;
  logic        bf_valid;
  logic [15:0] tw_idx;
  logic        wr_en;
  logic [15:0] wr_addr;
`ifdef FFT4_SCHED_PERF_EN
  logic [31:0] perf;
`endif

  int total = 0;
  int bad   = 0;
  int cn    = 0;

  always #5 clk = ~clk;

  fft4_stage_scheduler dut (
    .sys_clk_i  (clk),
    .rst_i      (rst),
    .start_i    (start),
    .hold_i     (hold),
    .busy_o     (busy),
    .done_o     (done),
    .stage_o    (stage),
    .rd_en_o    (rd_en),
    .rd_addr_o  (rd_addr),
    .bf_valid_o (bf_valid),
    .tw_idx_o   (tw_idx),
    .wr_en_o    (wr_en),
    .wr_addr_o  (wr_addr)
`ifdef FFT4_SCHED_PERF_EN
    ,
    .perf_cycles_o (perf)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s @%0d obs=%0h exp=%0h", tag, cn, obs, exp);
    end
  endtask

  // Advance one cycle, drive start/hold, then check every output.
  task automatic step(input logic st, input logic hd,
                      input logic rd, input logic [15:0] ra,
                      input logic bv, input logic [15:0] tw,
                      input logic we, input logic [15:0] wa,
                      input logic bsy, input logic dn,
                      input logic [1:0] sg);
    @(posedge clk);
    #1;
    start = st;
    hold  = hd;
    cn++;
    #1;
    chk("rd_en", 32'(rd_en), 32'(rd));
    chk("rd_addr", 32'(rd_addr), 32'(ra));
    chk("bf_valid", 32'(bf_valid), 32'(bv));
    chk("tw_idx", 32'(tw_idx), 32'(tw));
    chk("wr_en", 32'(wr_en), 32'(we));
    chk("wr_addr", 32'(wr_addr), 32'(wa));
    chk("busy", 32'(busy), 32'(bsy));
    chk("done", 32'(done), 32'(dn));
    chk("stage", 32'(stage), 32'(sg));
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    hold  = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rd", 32'(rd_en), 32'd0);
    chk("rst_bf", 32'(bf_valid), 32'd0);
    chk("rst_wr", 32'(wr_en), 32'd0);
    chk("rst_addr", 32'(rd_addr), 32'd0);
    chk("rst_waddr", 32'(wr_addr), 32'd0);
    chk("rst_tw", 32'(tw_idx), 32'd0);
    chk("rst_stage", 32'(stage), 32'd0);
`ifdef FFT4_SCHED_PERF_EN
    chk("rst_perf", perf, 32'd0);
`endif
    start = 1'b1;

    // Run 1: no holds; starts at 5 and 13 ignored, start at 14 taken.
    cn = 0;
    step(0,0, 1,16'hC840, 0,16'h0000, 0,16'h0000, 1,0,0);
    step(0,0, 1,16'hD951, 1,16'h0000, 0,16'h0000, 1,0,0);
    step(0,0, 1,16'hEA62, 1,16'h3210, 1,16'hC840, 1,0,0);
    step(0,0, 1,16'hFB73, 1,16'h6420, 1,16'hD951, 1,0,0);
    step(1,0, 0,16'h0000, 1,16'h9630, 1,16'hEA62, 1,0,0);
    step(0,0, 0,16'h0000, 0,16'h0000, 1,16'hFB73, 1,0,0);
    step(0,0, 1,16'h3210, 0,16'h0000, 0,16'h0000, 1,0,1);
    step(0,0, 1,16'h7654, 1,16'h0000, 0,16'h0000, 1,0,1);
    step(0,0, 1,16'hBA98, 1,16'h0000, 1,16'h3210, 1,0,1);
    step(0,0, 1,16'hFEDC, 1,16'h0000, 1,16'h7654, 1,0,1);
    step(0,0, 0,16'h0000, 1,16'h0000, 1,16'hBA98, 1,0,1);
    step(0,0, 0,16'h0000, 0,16'h0000, 1,16'hFEDC, 1,0,1);
    step(1,0, 0,16'h0000, 0,16'h0000, 0,16'h0000, 0,1,1);
    step(1,0, 0,16'h0000, 0,16'h0000, 0,16'h0000, 0,0,1);
`ifdef FFT4_SCHED_PERF_EN
    chk("perf", perf, 32'd13);
`endif

    // Run 2: hold in run cycles 2..3 pushes b=1 to cycle 4, done at 15.
    cn = 0;
    step(0,0, 1,16'hC840, 0,16'h0000, 0,16'h0000, 1,0,0);
    step(0,1, 0,16'h0000, 1,16'h0000, 0,16'h0000, 1,0,0);
    step(0,1, 0,16'h0000, 0,16'h0000, 1,16'hC840, 1,0,0);
    step(0,0, 1,16'hD951, 0,16'h0000, 0,16'h0000, 1,0,0);
    step(0,0, 1,16'hEA62, 1,16'h3210, 0,16'h0000, 1,0,0);
    step(0,0, 1,16'hFB73, 1,16'h6420, 1,16'hD951, 1,0,0);
    step(0,0, 0,16'h0000, 1,16'h9630, 1,16'hEA62, 1,0,0);
    step(0,0, 0,16'h0000, 0,16'h0000, 1,16'hFB73, 1,0,0);
    step(0,0, 1,16'h3210, 0,16'h0000, 0,16'h0000, 1,0,1);
    step(0,0, 1,16'h7654, 1,16'h0000, 0,16'h0000, 1,0,1);
    step(0,0, 1,16'hBA98, 1,16'h0000, 1,16'h3210, 1,0,1);
    step(0,0, 1,16'hFEDC, 1,16'h0000, 1,16'h7654, 1,0,1);
    step(0,0, 0,16'h0000, 1,16'h0000, 1,16'hBA98, 1,0,1);
    step(0,0, 0,16'h0000, 0,16'h0000, 1,16'hFEDC, 1,0,1);
    step(0,0, 0,16'h0000, 0,16'h0000, 0,16'h0000, 0,1,1);
    step(1,0, 0,16'h0000, 0,16'h0000, 0,16'h0000, 0,0,1);

    // Run 3: reset asserted in cycle 8 aborts the transform.
    cn = 0;
    step(0,0, 1,16'hC840, 0,16'h0000, 0,16'h0000, 1,0,0);
    step(0,0, 1,16'hD951, 1,16'h0000, 0,16'h0000, 1,0,0);
    step(0,0, 1,16'hEA62, 1,16'h3210, 1,16'hC840, 1,0,0);
    step(0,0, 1,16'hFB73, 1,16'h6420, 1,16'hD951, 1,0,0);
    step(0,0, 0,16'h0000, 1,16'h9630, 1,16'hEA62, 1,0,0);
    step(0,0, 0,16'h0000, 0,16'h0000, 1,16'hFB73, 1,0,0);
    step(0,0, 1,16'h3210, 0,16'h0000, 0,16'h0000, 1,0,1);
    step(0,0, 1,16'h7654, 1,16'h0000, 0,16'h0000, 1,0,1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step(0,0, 0,16'h0000, 0,16'h0000, 0,16'h0000, 0,0,0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
